// File: rtl/hazard_control_unit_pkg.sv
// Shared hazard-control types: FSM state, forwarding select codes
// and the default register address width.
package hazard_control_unit_pkg;

   localparam int HZ_REG_AW = 5;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      MEM_WAIT    = 2'd1,
      MULDIV_WAIT = 2'd2
   } hz_state_e;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/hazard_control_unit_reg_match.sv
// Register dependency comparator: source vs destination, x0 and valid qualified.
// Ports: src_i/use_i (reader), dst_i/regwrite_i (writer), match_o.
module hazard_reg_match
   import hazard_control_unit_pkg::*;
#(
   parameter int REG_AW = HZ_REG_AW
) (
   input  logic [REG_AW-1:0] src_i,
   input  logic              use_i,
   input  logic [REG_AW-1:0] dst_i,
   input  logic              regwrite_i,
   output logic              match_o
);

   assign match_o = use_i & regwrite_i
                  & (dst_i != '0)
                  & (src_i == dst_i);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: forwarding selects, load-use bubbles,
// memory-wait freezes and mul/div stalls with a sticky watchdog.
// Ports: ID sources, EX/MEM destinations, MEM_READY, MULDIV_BUSY in;
// HOLD_*/BUBBLE_* (Mealy), FWD_RS*_SEL and TIMEOUT_ERR (registered) out.
module hazard_control_unit
   import hazard_control_unit_pkg::*;
#(
   parameter int REG_AW         = HZ_REG_AW,
   parameter bit FWD_EN         = 1'b1,
   parameter int MULDIV_TIMEOUT = 64
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [REG_AW-1:0] ID_RS1,
   input  logic [REG_AW-1:0] ID_RS2,
   input  logic              ID_USE_RS1,
   input  logic              ID_USE_RS2,
   input  logic [REG_AW-1:0] EX_RD,
   input  logic [REG_AW-1:0] MEM_RD,
   input  logic              EX_REGWRITE,
   input  logic              MEM_REGWRITE,
   input  logic              EX_LOAD,
   input  logic              MEM_LOAD,
   input  logic              MEM_READY,
   input  logic              MULDIV_BUSY,
   output logic              HOLD_FE,
   output logic              HOLD_EX,
   output logic              HOLD_ALL,
   output logic              BUBBLE_EX,
   output logic              BUBBLE_MEM,
   output logic [1:0]        FWD_RS1_SEL,
   output logic [1:0]        FWD_RS2_SEL,
   output logic              TIMEOUT_ERR
);

   localparam int CW = $clog2(MULDIV_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MULDIV_TIMEOUT);

   hz_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q;
   logic [1:0]    sel1_q, sel1_d;
   logic [1:0]    sel2_q, sel2_d;

   logic ex1, ex2, mem1, mem2;
   logic ex_hit, mem_hit;
   logic mem_stall, raw_stall;

   hazard_reg_match #(.REG_AW(REG_AW)) u_ex1 (
      .src_i(ID_RS1), .use_i(ID_USE_RS1),
      .dst_i(EX_RD), .regwrite_i(EX_REGWRITE),
      .match_o(ex1)
   );

   hazard_reg_match #(.REG_AW(REG_AW)) u_ex2 (
      .src_i(ID_RS2), .use_i(ID_USE_RS2),
      .dst_i(EX_RD), .regwrite_i(EX_REGWRITE),
      .match_o(ex2)
   );

   hazard_reg_match #(.REG_AW(REG_AW)) u_mem1 (
      .src_i(ID_RS1), .use_i(ID_USE_RS1),
      .dst_i(MEM_RD), .regwrite_i(MEM_REGWRITE),
      .match_o(mem1)
   );

   hazard_reg_match #(.REG_AW(REG_AW)) u_mem2 (
      .src_i(ID_RS2), .use_i(ID_USE_RS2),
      .dst_i(MEM_RD), .regwrite_i(MEM_REGWRITE),
      .match_o(mem2)
   );

   assign ex_hit    = ex1 | ex2;
   assign mem_hit   = mem1 | mem2;
   assign mem_stall = MEM_LOAD & ~MEM_READY;

   // Without forwarding every EX/MEM RAW dependency has to wait out.
   assign raw_stall = (EX_LOAD & ex_hit)
                    | (~FWD_EN & (ex_hit | mem_hit));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      HOLD_FE    = 1'b0;
      HOLD_EX    = 1'b0;
      HOLD_ALL   = 1'b0;
      BUBBLE_EX  = 1'b0;
      BUBBLE_MEM = 1'b0;
      unique case (state_q)
         RUN, MULDIV_WAIT: begin
            if (mem_stall) begin
               HOLD_ALL = 1'b1;
               state_d  = MEM_WAIT;
            end else if (MULDIV_BUSY) begin
               HOLD_FE    = 1'b1;
               HOLD_EX    = 1'b1;
               BUBBLE_MEM = 1'b1;
               state_d    = MULDIV_WAIT;
               if (state_q == RUN)
                  cnt_d = '0;
               else if (cnt_q != CNT_MAX)
                  cnt_d = cnt_q + CW'(1);
            end else begin
               state_d = RUN;
               if (raw_stall) begin
                  HOLD_FE   = 1'b1;
                  BUBBLE_EX = 1'b1;
               end
            end
         end
         MEM_WAIT: begin
            HOLD_ALL = ~MEM_READY;
            if (MEM_READY)
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      if (RESET) begin
         HOLD_FE    = 1'b0;
         HOLD_EX    = 1'b0;
         HOLD_ALL   = 1'b0;
         BUBBLE_EX  = 1'b0;
         BUBBLE_MEM = 1'b0;
      end
   end

   // Selects for the operand about to enter EX; frozen while EX is held.
   always_comb begin
      sel1_d = FWD_RF;
      sel2_d = FWD_RF;
      if (HOLD_EX | HOLD_ALL) begin
         sel1_d = sel1_q;
         sel2_d = sel2_q;
      end else if (!BUBBLE_EX && FWD_EN) begin
         sel1_d = ex1 ? FWD_EXMEM : (mem1 ? FWD_MEMWB : FWD_RF);
         sel2_d = ex2 ? FWD_EXMEM : (mem2 ? FWD_MEMWB : FWD_RF);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= RUN;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         sel1_q  <= FWD_RF;
         sel2_q  <= FWD_RF;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_q | (cnt_d == CNT_MAX);
         sel1_q  <= sel1_d;
         sel2_q  <= sel2_d;
      end
   end

   assign FWD_RS1_SEL = sel1_q;
   assign FWD_RS2_SEL = sel2_q;
   assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed vectors push expected
// output words; a negedge monitor pops and compares them.
module tb_hazard_control_unit;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [4:0] ID_RS1, ID_RS2, EX_RD, MEM_RD;
   logic       ID_USE_RS1, ID_USE_RS2;
   logic       EX_REGWRITE, MEM_REGWRITE;
   logic       EX_LOAD, MEM_LOAD, MEM_READY, MULDIV_BUSY;

   logic       fe, hx, ha, bx, bm, er;
   logic [1:0] s1, s2;
   logic       nfe, nhx, nha, nbx, nbm, ner;
   logic [1:0] ns1, ns2;

   int total = 0;
   int bad = 0;

   string      qn[$];
   logic [9:0] qe[$];
   logic [9:0] qm[$];
   bit         qc[$];
   logic [9:0] qf[$];

   always #5 CLK = ~CLK;

   hazard_control_unit #(
      .REG_AW(5), .FWD_EN(1'b1), .MULDIV_TIMEOUT(64)
   ) u_dut (
      .CLK(CLK), .RESET(RESET),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
      .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
      .EX_RD(EX_RD), .MEM_RD(MEM_RD),
      .EX_REGWRITE(EX_REGWRITE), .MEM_REGWRITE(MEM_REGWRITE),
      .EX_LOAD(EX_LOAD), .MEM_LOAD(MEM_LOAD),
      .MEM_READY(MEM_READY), .MULDIV_BUSY(MULDIV_BUSY),
      .HOLD_FE(fe), .HOLD_EX(hx), .HOLD_ALL(ha),
      .BUBBLE_EX(bx), .BUBBLE_MEM(bm),
      .FWD_RS1_SEL(s1), .FWD_RS2_SEL(s2),
      .TIMEOUT_ERR(er)
   );

   hazard_control_unit #(
      .REG_AW(5), .FWD_EN(1'b0), .MULDIV_TIMEOUT(64)
   ) u_dut_nf (
      .CLK(CLK), .RESET(RESET),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
      .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
      .EX_RD(EX_RD), .MEM_RD(MEM_RD),
      .EX_REGWRITE(EX_REGWRITE), .MEM_REGWRITE(MEM_REGWRITE),
      .EX_LOAD(EX_LOAD), .MEM_LOAD(MEM_LOAD),
      .MEM_READY(MEM_READY), .MULDIV_BUSY(MULDIV_BUSY),
      .HOLD_FE(nfe), .HOLD_EX(nhx), .HOLD_ALL(nha),
      .BUBBLE_EX(nbx), .BUBBLE_MEM(nbm),
      .FWD_RS1_SEL(ns1), .FWD_RS2_SEL(ns2),
      .TIMEOUT_ERR(ner)
   );

   wire [9:0] got    = {fe, hx, ha, bx, bm, s1, s2, er};
   wire [9:0] got_nf = {nfe, nhx, nha, nbx, nbm, ns1, ns2, ner};

   // Word layout: fe hx ha bx bm s1[1:0] s2[1:0] err
   function automatic logic [9:0] E(input bit f, input bit h,
                                    input bit a, input bit b,
                                    input bit m, input logic [1:0] a1,
                                    input logic [1:0] a2, input bit e);
      return {f, h, a, b, m, a1, a2, e};
   endfunction

   always @(negedge CLK) begin
      if (qn.size() > 0) begin
         string      n;
         logic [9:0] e, m, f;
         bit         c;
         n = qn.pop_front();
         e = qe.pop_front();
         m = qm.pop_front();
         c = qc.pop_front();
         f = qf.pop_front();
         total++;
         if ((got & m) !== (e & m)) begin
            bad++;
            $display("FAIL %s got=%b exp=%b mask=%b", n, got, e, m);
         end
         if (c) begin
            total++;
            if (got_nf !== f) begin
               bad++;
               $display("FAIL %s_nf got=%b exp=%b", n, got_nf, f);
            end
         end
      end
   end

   task automatic push(input string n, input logic [9:0] e,
                       input logic [9:0] m, input bit c,
                       input logic [9:0] f);
      qn.push_back(n);
      qe.push_back(e);
      qm.push_back(m);
      qc.push_back(c);
      qf.push_back(f);
   endtask

   task automatic chk(input string n, input logic [9:0] e);
      push(n, e, 10'h3FF, 1'b0, 10'h0);
   endtask

   task automatic chkn(input string n, input logic [9:0] e,
                       input logic [9:0] f);
      push(n, e, 10'h3FF, 1'b1, f);
   endtask

   task automatic idle();
      ID_RS1 = 0; ID_RS2 = 0; ID_USE_RS1 = 0; ID_USE_RS2 = 0;
      EX_RD = 0; EX_REGWRITE = 0; EX_LOAD = 0;
      MEM_RD = 0; MEM_REGWRITE = 0; MEM_LOAD = 0;
      MEM_READY = 1; MULDIV_BUSY = 0;
   endtask

   task automatic nxt();
      @(posedge CLK);
      #1;
      idle();
   endtask

   task automatic ex(input logic [4:0] rd, input bit w, input bit l);
      EX_RD = rd; EX_REGWRITE = w; EX_LOAD = l;
   endtask

   task automatic mem(input logic [4:0] rd, input bit w,
                      input bit l, input bit rdy);
      MEM_RD = rd; MEM_REGWRITE = w; MEM_LOAD = l; MEM_READY = rdy;
   endtask

   task automatic id(input logic [4:0] r1, input bit u1,
                     input logic [4:0] r2, input bit u2);
      ID_RS1 = r1; ID_USE_RS1 = u1; ID_RS2 = r2; ID_USE_RS2 = u2;
   endtask

   localparam logic [9:0] Z = 10'h0;

   initial begin
      idle();
      RESET = 1'b1;
      repeat (2) @(posedge CLK);

      // outputs forced low while RESET is high
      nxt(); RESET = 1'b1;
      MEM_LOAD = 1; MEM_READY = 0; MULDIV_BUSY = 1;
      ex(7, 1, 1); id(7, 1, 0, 0);
      chkn("rst_force", Z, Z);
      nxt(); RESET = 1'b0;
      chkn("rst_idle", Z, Z);

      // EX forwarding
      nxt(); ex(5, 1, 0); id(5, 1, 6, 1);
      chk("fwd_ex_issue", Z);
      nxt(); chk("fwd_ex_sel", E(0,0,0,0,0,2'b01,2'b00,0));

      // x0 never matches
      nxt(); ex(0, 1, 0); id(0, 1, 0, 1);
      chkn("x0_issue", Z, Z);
      nxt(); chkn("x0_sel", Z, Z);

      // MEM forwarding
      nxt(); mem(9, 1, 0, 1); id(0, 0, 9, 1);
      chk("fwd_mem_issue", Z);
      nxt(); chk("fwd_mem_sel", E(0,0,0,0,0,2'b00,2'b10,0));

      // EX beats MEM
      nxt(); ex(3, 1, 0); mem(3, 1, 0, 1); id(3, 1, 0, 0);
      chk("prio_issue", Z);
      nxt(); chk("prio_sel", E(0,0,0,0,0,2'b01,2'b00,0));

      // unused source does not match
      nxt(); ex(4, 1, 0); id(4, 0, 0, 0);
      chk("nouse_issue", Z);
      nxt(); chk("nouse_sel", Z);

      // load-use: one bubble then MEM/WB forward
      nxt(); ex(7, 1, 1); id(7, 1, 0, 0);
      chk("lu_bubble", E(1,0,0,1,0,2'b00,2'b00,0));
      nxt(); mem(7, 1, 1, 1); id(7, 1, 0, 0);
      chk("lu_after", Z);
      nxt(); chk("lu_sel10", E(0,0,0,0,0,2'b10,2'b00,0));

      // dependent load chain: one bubble per load
      nxt(); ex(1, 1, 1); id(1, 1, 0, 0);
      chk("ch1_bubble", E(1,0,0,1,0,2'b00,2'b00,0));
      nxt(); mem(1, 1, 1, 1); id(1, 1, 0, 0);
      chk("ch1_go", Z);
      nxt(); ex(2, 1, 1); id(2, 1, 0, 0);
      chk("ch2_bubble", E(1,0,0,1,0,2'b10,2'b00,0));
      nxt(); mem(2, 1, 1, 1); id(2, 1, 0, 0);
      chk("ch2_go", Z);
      nxt(); chk("ch2_sel", E(0,0,0,0,0,2'b10,2'b00,0));

      // memory not ready for 3 cycles
      nxt(); ex(5, 1, 0); id(5, 1, 0, 0);
      chk("mw_pre", Z);
      nxt(); mem(8, 1, 1, 0);
      chk("mw_h1", E(0,0,1,0,0,2'b01,2'b00,0));
      nxt(); mem(8, 1, 1, 0);
      chk("mw_h2", E(0,0,1,0,0,2'b01,2'b00,0));
      nxt(); mem(8, 1, 1, 0);
      chk("mw_h3", E(0,0,1,0,0,2'b01,2'b00,0));
      nxt(); mem(8, 1, 1, 1);
      chk("mw_rel", E(0,0,0,0,0,2'b01,2'b00,0));
      nxt(); chk("mw_run", Z);

      // mul/div busy 10 cycles
      for (int i = 0; i < 10; i++) begin
         nxt(); MULDIV_BUSY = 1;
         chk("md10", E(1,1,0,0,1,2'b00,2'b00,0));
      end
      nxt(); chk("md10_rel", Z);

      // memory wait overrides mul/div wait, busy re-evaluated after
      nxt(); MULDIV_BUSY = 1;
      chk("mx_md", E(1,1,0,0,1,2'b00,2'b00,0));
      nxt(); MULDIV_BUSY = 1; mem(8, 1, 1, 0);
      chk("mx_mem", E(0,0,1,0,0,2'b00,2'b00,0));
      nxt(); MULDIV_BUSY = 1; mem(8, 1, 1, 1);
      chk("mx_rel", Z);
      nxt(); MULDIV_BUSY = 1;
      chk("mx_md2", E(1,1,0,0,1,2'b00,2'b00,0));
      nxt(); chk("mx_end", Z);

      // no forwarding: MEM RAW match stalls one cycle
      nxt(); mem(5, 1, 0, 1); id(5, 1, 0, 0);
      chkn("nf_issue", Z, E(1,0,0,1,0,2'b00,2'b00,0));
      nxt(); id(5, 1, 0, 0);
      chkn("nf_after", E(0,0,0,0,0,2'b10,2'b00,0), Z);
      nxt(); chkn("nf_end", Z, Z);

      // watchdog: busy 70 cycles
      for (int k = 1; k <= 70; k++) begin
         nxt(); MULDIV_BUSY = 1;
         if (k <= 60)
            chk("to_early", E(1,1,0,0,1,2'b00,2'b00,0));
         else if (k == 70)
            chk("to_set", E(1,1,0,0,1,2'b00,2'b00,1));
         else
            push("to_mid", E(1,1,0,0,1,2'b00,2'b00,0),
                 10'h3FE, 1'b0, Z);
      end
      nxt(); chkn("to_rel", E(0,0,0,0,0,2'b00,2'b00,1),
                  E(0,0,0,0,0,2'b00,2'b00,1));
      nxt(); chk("to_sticky", E(0,0,0,0,0,2'b00,2'b00,1));

      // reset during memory wait
      nxt(); ex(5, 1, 0); id(5, 1, 0, 0);
      chk("rm_pre", E(0,0,0,0,0,2'b00,2'b00,1));
      nxt(); mem(8, 1, 1, 0);
      chk("rm_h1", E(0,0,1,0,0,2'b01,2'b00,1));
      nxt(); mem(8, 1, 1, 0);
      chk("rm_h2", E(0,0,1,0,0,2'b01,2'b00,1));
      nxt(); RESET = 1'b1; mem(8, 1, 1, 0);
      chk("rm_rst", E(0,0,0,0,0,2'b01,2'b00,1));
      nxt(); RESET = 1'b0; MEM_READY = 0;
      chkn("rm_after", Z, Z);
      nxt(); chk("rm_idle", Z);

      nxt();
      for (int w = 0; w < 5 && qn.size() > 0; w++)
         @(negedge CLK);
      if (qn.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d required=0", qn.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
